display_scan_ctrl: RTL
======================

# display_scan_ctrl

Parametrised multi-digit seven-segment scan controller: generates its own digit-scan timing from the system clock, selects per-digit hex nibble, decimal point and LE bit, and drives active-low anode enables. It adds brightness (PWM within each digit slot), per-digit blinking and tear-free frame latching of display data. It sits between the counter/datapath logic and the seven-segment decoder/board pins, and replaces hand-driven external scan inputs.

## Interface
- N_DIGITS, 8: number of digits scanned, 2..16.
- DIV_BITS, 17: digit slot length is 2^DIV_BITS clocks; must be >= 4.
- BLINK_BITS, 5: blink phase toggles every 2^(BLINK_BITS-1) frames.
- clk  in  1  system clock; the block uses this single clock, all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  scan enable; low freezes scan state and blanks all anodes.
- hexs  in  4*N_DIGITS  nibble i at [4i+3:4i] is shown on digit i.
- points  in  N_DIGITS  decimal-point bit per digit, passed through unmodified.
- LEs  in  N_DIGITS  LE bit per digit, passed through unmodified.
- blink_mask  in  N_DIGITS  1 = digit blanked during blink-off phase.
- brightness  in  4  0 = dimmest lit (1/16 duty), 15 = full duty.
- HEX  out  4  selected nibble.
- AN  out  N_DIGITS  anode enables, active-low, one-hot-low when lit, all ones when blank.
- point  out  1  selected point bit.
- LE  out  1  selected LE bit.
- scan_idx  out  $clog2(N_DIGITS)  index of the digit currently selected.
- frame_done  out  1  one-cycle pulse when the last digit slot ends.

## Operation
- Prescaler cnt (DIV_BITS wide) increments each cycle with en=1; at all-ones it wraps to 0 and idx advances; idx wraps N_DIGITS-1 -> 0.
- Frame wrap = en && cnt all-ones && idx == N_DIGITS-1: frame_done pulses, blink frame counter (BLINK_BITS) increments, wrapping naturally.
- Shadow registers (hexs, points, LEs, blink_mask, brightness) load on frame wrap, and on the first en=1 cycle after reset (primed flag). Inputs changing mid-frame never affect the current frame.
- lit = en && (cnt[DIV_BITS-1 -: 4] <= shadow brightness) && !(shadow blink_mask[idx] && blink counter MSB).
- AN = lit ? ~(1 << idx) : all ones. HEX/point/LE follow idx from shadow data regardless of lit.
- en=0: cnt, idx, blink counter hold; AN all ones; frame_done 0; shadows hold.

## Timing
- All outputs registered: output at edge t+1 reflects cnt/idx/shadow state during cycle t (1-cycle latency).
- Reset values: HEX=0, AN=all ones, point=0, LE=0, scan_idx=0, frame_done=0; cnt, idx, blink counter, shadows, primed all 0.
- rst mid-frame takes effect next edge, overrides en; first lit output appears 2 cycles after rst deasserts with en=1 (primed load, then registered output).
- Frame length exactly N_DIGITS*2^DIV_BITS enabled cycles; frame_done asserted for the cycle after the wrap cycle.
- brightness=15: AN low for the whole slot; brightness=b: AN low for (b+1)*2^(DIV_BITS-4) cycles at slot start.
- Non-power-of-two N_DIGITS: idx never reaches values >= N_DIGITS.

## Structure
- Shared header display_defs.vh: AN-off constant generator, brightness width (4), scan index width function.
- One sub-module natural: scan_prescaler (cnt + idx + frame wrap + blink counter), leaving selection, shadowing and PWM/blink gating in the top.

## Test plan
- N_DIGITS=4, DIV_BITS=4, brightness=15, en=1 after reset: AN sequence 1110,1101,1011,0111 each 16 cycles; frame_done pulses every 64 cycles; HEX matches hexs nibbles.
- brightness=3, DIV_BITS=4: per slot AN low 4 cycles, high 12; brightness=0: low 1 cycle.
- hexs changed mid-frame from 0x1234 to 0xABCD: remaining slots of that frame still show 1,2,3,4 order; next frame shows new nibbles.
- blink_mask=0010, BLINK_BITS=2: digit 1 anode lit in frames 0-1, blank in frames 2-3, repeat; other digits unaffected.
- en dropped mid-slot for 10 cycles: AN all ones, scan_idx and cnt frozen; resume continues same slot with remaining cycles.
- rst asserted during idx=2: next cycle all outputs at reset values; after release, scanning restarts at digit 0 with freshly latched data.

Source files
------------

// File: rtl/display_scan_ctrl_pkg.sv
// Shared definitions for the seven-segment scan controller.
//   BRIGHT_W   : width of the brightness code (16 PWM levels per digit slot)
//   MAX_DIGITS : largest supported digit count
//   bright_t   : brightness code type
//   idx_width  : width of a digit index for a given digit count
//   an_off     : all-anodes-off pattern (active-low, so all ones) for n digits
package display_scan_ctrl_pkg;

  localparam int BRIGHT_W   = 4;
  localparam int MAX_DIGITS = 16;

  typedef logic [BRIGHT_W-1:0] bright_t;

  function automatic int idx_width(input int n_digits);
    return (n_digits > 1) ? $clog2(n_digits) : 1;
  endfunction

  function automatic logic [MAX_DIGITS-1:0] an_off(input int n_digits);
    logic [MAX_DIGITS-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < n_digits) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Bundle between the datapath (master) and the scan controller (slave).
//   Datapath -> controller : en, hexs, points, LEs, blink_mask, brightness
//   Controller -> datapath/pins : HEX, AN, point, LE, scan_idx, frame_done
interface display_scan_ctrl_if
  import display_scan_ctrl_pkg::*;
#(
  parameter int N_DIGITS = 8
);

  localparam int IDX_W = idx_width(N_DIGITS);

  logic                  en;
  logic [4*N_DIGITS-1:0] hexs;
  logic [N_DIGITS-1:0]   points;
  logic [N_DIGITS-1:0]   LEs;
  logic [N_DIGITS-1:0]   blink_mask;
  bright_t               brightness;

  logic [3:0]            HEX;
  logic [N_DIGITS-1:0]   AN;
  logic                  point;
  logic                  LE;
  logic [IDX_W-1:0]      scan_idx;
  logic                  frame_done;

  modport master (
    output en, hexs, points, LEs, blink_mask, brightness,
    input  HEX, AN, point, LE, scan_idx, frame_done
  );

  modport slave (
    input  en, hexs, points, LEs, blink_mask, brightness,
    output HEX, AN, point, LE, scan_idx, frame_done
  );

endinterface

// File: rtl/display_scan_ctrl_scan_prescaler.sv
// Scan timing generator: slot prescaler, digit index, frame wrap and blink
// frame counter. Everything holds while en is low.
//   clk, rst  : clock, synchronous active-high reset
//   en        : advance enable
//   phase     : top BRIGHT_W bits of the slot prescaler (PWM phase in slot)
//   idx       : current digit index, 0..N_DIGITS-1
//   wrap      : combinational, high in the last enabled cycle of a frame
//   blink_msb : blink phase (MSB of the frame counter)
module display_scan_ctrl_scan_prescaler
  import display_scan_ctrl_pkg::*;
#(
  parameter int N_DIGITS   = 8,
  parameter int DIV_BITS   = 17,
  parameter int BLINK_BITS = 5,
  parameter int IDX_W      = idx_width(N_DIGITS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output bright_t          phase,
  output logic [IDX_W-1:0] idx,
  output logic             wrap,
  output logic             blink_msb
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);

  logic [DIV_BITS-1:0]   cnt;
  logic [BLINK_BITS-1:0] blink_cnt;
  logic                  slot_end;

  assign slot_end  = en && (&cnt);
  assign wrap      = slot_end && (idx == LAST_IDX);
  assign phase     = cnt[DIV_BITS-1 -: BRIGHT_W];
  assign blink_msb = blink_cnt[BLINK_BITS-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      idx       <= '0;
      blink_cnt <= '0;
    end else begin
      if (en) cnt <= cnt + DIV_BITS'(1);
      // Explicit wrap keeps idx inside 0..N_DIGITS-1 for non-power-of-two counts.
      if (slot_end) idx <= wrap ? '0 : idx + IDX_W'(1);
      if (wrap) blink_cnt <= blink_cnt + BLINK_BITS'(1);
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Multi-digit seven-segment scan controller with brightness PWM, per-digit
// blinking and frame-synchronous latching of display data.
//   clk  : system clock (rising edge)
//   rst  : synchronous active-high reset
//   bus  : slave side of display_scan_ctrl_if
//          inputs  en, hexs, points, LEs, blink_mask, brightness
//          outputs HEX, AN (active-low), point, LE, scan_idx, frame_done
// All outputs are registered: they reflect the scan/shadow state of the
// previous cycle.
module display_scan_ctrl
  import display_scan_ctrl_pkg::*;
#(
  parameter int N_DIGITS   = 8,
  parameter int DIV_BITS   = 17,
  parameter int BLINK_BITS = 5
) (
  input logic                clk,
  input logic                rst,
  display_scan_ctrl_if.slave bus
);

  localparam int                  IDX_W  = idx_width(N_DIGITS);
  localparam logic [N_DIGITS-1:0] AN_OFF = N_DIGITS'(an_off(N_DIGITS));
  localparam logic [N_DIGITS-1:0] AN_ONE = N_DIGITS'(1);

  bright_t             phase;
  logic [IDX_W-1:0]    idx;
  logic                wrap;
  logic                blink_msb;

  logic [3:0]          sh_hex [N_DIGITS];
  logic [N_DIGITS-1:0] sh_points;
  logic [N_DIGITS-1:0] sh_les;
  logic [N_DIGITS-1:0] sh_blink;
  bright_t             sh_bright;
  logic                primed;
  logic                load;

  logic                blink_off;
  logic                lit;
  logic [N_DIGITS-1:0] an_sel;

  logic [3:0]          hex_p1;
  logic [N_DIGITS-1:0] an_p1;
  logic                point_p1;
  logic                le_p1;
  logic [IDX_W-1:0]    idx_p1;
  logic                fd_p1;

  display_scan_ctrl_scan_prescaler #(
    .N_DIGITS  (N_DIGITS),
    .DIV_BITS  (DIV_BITS),
    .BLINK_BITS(BLINK_BITS),
    .IDX_W     (IDX_W)
  ) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .en       (bus.en),
    .phase    (phase),
    .idx      (idx),
    .wrap     (wrap),
    .blink_msb(blink_msb)
  );

  // ---- stage p0: frame-synchronous shadow of display data ----
  // Loading only at frame wrap (or the very first enabled cycle) keeps one
  // frame internally consistent whatever the datapath does mid-frame.
  assign load = bus.en && (wrap || !primed);

  always_ff @(posedge clk) begin
    if (rst) begin
      primed    <= 1'b0;
      sh_points <= '0;
      sh_les    <= '0;
      sh_blink  <= '0;
      sh_bright <= '0;
      for (int i = 0; i < N_DIGITS; i++) sh_hex[i] <= '0;
    end else begin
      if (bus.en) primed <= 1'b1;
      if (load) begin
        sh_points <= bus.points;
        sh_les    <= bus.LEs;
        sh_blink  <= bus.blink_mask;
        sh_bright <= bus.brightness;
        for (int i = 0; i < N_DIGITS; i++) sh_hex[i] <= bus.hexs[4*i +: 4];
      end
    end
  end

  // The unprimed cycle is blanked: its shadow still holds reset data.
  assign blink_off = sh_blink[idx] && blink_msb;
  assign lit       = bus.en && primed && (phase <= sh_bright) && !blink_off;
  assign an_sel    = ~(AN_ONE << idx);

  // ---- stage p1: registered outputs ----
  always_ff @(posedge clk) begin
    if (rst) begin
      hex_p1   <= '0;
      an_p1    <= AN_OFF;
      point_p1 <= 1'b0;
      le_p1    <= 1'b0;
      idx_p1   <= '0;
      fd_p1    <= 1'b0;
    end else begin
      hex_p1   <= sh_hex[idx];
      an_p1    <= lit ? an_sel : AN_OFF;
      point_p1 <= sh_points[idx];
      le_p1    <= sh_les[idx];
      idx_p1   <= idx;
      fd_p1    <= wrap;
    end
  end

  assign bus.HEX        = hex_p1;
  assign bus.AN         = an_p1;
  assign bus.point      = point_p1;
  assign bus.LE         = le_p1;
  assign bus.scan_idx   = idx_p1;
  assign bus.frame_done = fd_p1;

endmodule
